// File: rtl/pll_rst_ctrl.sv
// pll_rst_ctrl: staged reset sequencer fed by an asynchronous PLL lock.
// Debounces lock, releases rst_n_out[0..NUM_RST-1] in order, and pulls
// everything back low on lock loss. Runs on the PLL reference clock.
// Optional lock-timeout watchdog driving the PLL RST pin: PLL_RST_CTRL_WATCHDOG_EN.
module pll_rst_ctrl #(
    parameter int LOCK_STABLE_CYCLES = 1000,
    parameter int NUM_RST            = 4,
    parameter int STAGE_GAP          = 16,
    parameter int LOCK_TIMEOUT       = 500000,
    parameter int PLL_RST_CYCLES     = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pll_lock,
    output logic [NUM_RST-1:0] rst_n_out,
    output logic               locked_stable,
    output logic [7:0]         lock_loss_cnt,
    output logic               pll_rst
);

    localparam int SCW = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
    localparam int GW  = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
    localparam int KW  = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;

    localparam logic [SCW-1:0] STAB_LAST = SCW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [GW-1:0]  GAP_LAST  = GW'(STAGE_GAP - 1);
    localparam logic [KW-1:0]  K_LAST    = KW'(NUM_RST - 1);

    // Elaboration-time parameter sanity checks.
    if (NUM_RST < 1 || NUM_RST > 8) begin : g_bad_num_rst
        $error("pll_rst_ctrl: NUM_RST must be 1..8");
    end
    if (STAGE_GAP < 1 || LOCK_STABLE_CYCLES < 1) begin : g_bad_counts
        $error("pll_rst_ctrl: STAGE_GAP and LOCK_STABLE_CYCLES must be >= 1");
    end
    if (LOCK_TIMEOUT < 1 || PLL_RST_CYCLES < 1) begin : g_bad_watchdog
        $error("pll_rst_ctrl: LOCK_TIMEOUT and PLL_RST_CYCLES must be >= 1");
    end

`ifdef PLL_RST_CTRL_WATCHDOG_EN
    localparam int TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam int PW = (PLL_RST_CYCLES > 1) ? $clog2(PLL_RST_CYCLES) : 1;
    localparam logic [TW-1:0] WD_LAST  = TW'(LOCK_TIMEOUT - 1);
    localparam logic [PW-1:0] PRC_LAST = PW'(PLL_RST_CYCLES - 1);

    typedef enum logic [2:0] {
        WAIT_LOCK, STABLE, RELEASE, RUN, PLL_RST
    } state_t;
`else
    typedef enum logic [1:0] {
        WAIT_LOCK, STABLE, RELEASE, RUN
    } state_t;
`endif

    state_t             state_q, state_d;
    logic [1:0]         sync_q, sync_d;
    logic [SCW-1:0]     stab_cnt_q, stab_cnt_d;
    logic [GW-1:0]      gap_q, gap_d;
    logic [KW-1:0]      stage_q, stage_d;
    logic [NUM_RST-1:0] rst_n_out_q, rst_n_out_d;
    logic               locked_stable_q, locked_stable_d;
    logic [7:0]         lock_loss_cnt_q, lock_loss_cnt_d;
    logic               lock_s;
`ifdef PLL_RST_CTRL_WATCHDOG_EN
    logic [TW-1:0]      wd_q, wd_d;
    logic [PW-1:0]      prc_q, prc_d;
    logic               pll_rst_q, pll_rst_d;
    logic               wd_fire;
`endif

    // Two-flop synchronizer for the asynchronous lock input.
    always_comb begin
        sync_d = {sync_q[0], pll_lock};
    end

    assign lock_s = sync_q[1];

    // Next-state and registered-output logic for the sequencer FSM.
    always_comb begin
        state_d         = state_q;
        stab_cnt_d      = stab_cnt_q;
        gap_d           = gap_q;
        stage_d         = stage_q;
        rst_n_out_d     = rst_n_out_q;
        locked_stable_d = locked_stable_q;
        lock_loss_cnt_d = lock_loss_cnt_q;
`ifdef PLL_RST_CTRL_WATCHDOG_EN
        wd_d      = wd_q;
        prc_d     = prc_q;
        pll_rst_d = pll_rst_q;
        wd_fire   = (wd_q == WD_LAST);
`endif
        case (state_q)
            WAIT_LOCK: begin
                rst_n_out_d     = '0;
                locked_stable_d = 1'b0;
`ifdef PLL_RST_CTRL_WATCHDOG_EN
                if (wd_fire) begin
                    state_d   = PLL_RST;
                    prc_d     = '0;
                    pll_rst_d = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                    if (lock_s) begin
                        state_d    = STABLE;
                        stab_cnt_d = '0;
                    end
                end
`else
                if (lock_s) begin
                    state_d    = STABLE;
                    stab_cnt_d = '0;
                end
`endif
            end
            STABLE: begin
                if (lock_s && stab_cnt_q == STAB_LAST) begin
                    // Release takes priority over a watchdog expiring on the same edge.
                    gap_d   = '0;
                    stage_d = '0;
`ifdef PLL_RST_CTRL_WATCHDOG_EN
                    wd_d = '0;
`endif
                    if (NUM_RST == 1) begin
                        state_d         = RUN;
                        rst_n_out_d     = '1;
                        locked_stable_d = 1'b1;
                    end else begin
                        state_d     = RELEASE;
                        rst_n_out_d = NUM_RST'(1);
                    end
`ifdef PLL_RST_CTRL_WATCHDOG_EN
                end else if (wd_fire) begin
                    state_d   = PLL_RST;
                    prc_d     = '0;
                    pll_rst_d = 1'b1;
`endif
                end else if (!lock_s) begin
                    // Dropout before release: just restart, not a loss event.
                    state_d = WAIT_LOCK;
`ifdef PLL_RST_CTRL_WATCHDOG_EN
                    wd_d = wd_q + 1'b1;
`endif
                end else begin
                    stab_cnt_d = stab_cnt_q + 1'b1;
`ifdef PLL_RST_CTRL_WATCHDOG_EN
                    wd_d = wd_q + 1'b1;
`endif
                end
            end
            RELEASE, RUN: begin
                if (!lock_s) begin
                    state_d         = WAIT_LOCK;
                    rst_n_out_d     = '0;
                    locked_stable_d = 1'b0;
                    if (lock_loss_cnt_q != 8'hFF) begin
                        lock_loss_cnt_d = lock_loss_cnt_q + 8'd1;
                    end
                end else if (state_q == RELEASE) begin
                    if (gap_q == GAP_LAST) begin
                        gap_d   = '0;
                        stage_d = stage_q + 1'b1;
                        for (int i = 0; i < NUM_RST; i++) begin
                            if (KW'(i) == stage_d) begin
                                rst_n_out_d[i] = 1'b1;
                            end
                        end
                        if (stage_d == K_LAST) begin
                            state_d         = RUN;
                            locked_stable_d = 1'b1;
                        end
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
            end
`ifdef PLL_RST_CTRL_WATCHDOG_EN
            PLL_RST: begin
                // Lock is ignored here; the PLL is being reset.
                rst_n_out_d     = '0;
                locked_stable_d = 1'b0;
                if (prc_q == PRC_LAST) begin
                    state_d   = WAIT_LOCK;
                    pll_rst_d = 1'b0;
                    wd_d      = '0;
                end else begin
                    prc_d = prc_q + 1'b1;
                end
            end
`endif
            default: begin
                state_d = WAIT_LOCK;
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= WAIT_LOCK;
            sync_q          <= '0;
            stab_cnt_q      <= '0;
            gap_q           <= '0;
            stage_q         <= '0;
            rst_n_out_q     <= '0;
            locked_stable_q <= 1'b0;
            lock_loss_cnt_q <= '0;
`ifdef PLL_RST_CTRL_WATCHDOG_EN
            wd_q      <= '0;
            prc_q     <= '0;
            pll_rst_q <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            sync_q          <= sync_d;
            stab_cnt_q      <= stab_cnt_d;
            gap_q           <= gap_d;
            stage_q         <= stage_d;
            rst_n_out_q     <= rst_n_out_d;
            locked_stable_q <= locked_stable_d;
            lock_loss_cnt_q <= lock_loss_cnt_d;
`ifdef PLL_RST_CTRL_WATCHDOG_EN
            wd_q      <= wd_d;
            prc_q     <= prc_d;
            pll_rst_q <= pll_rst_d;
`endif
        end
    end

    assign rst_n_out     = rst_n_out_q;
    assign locked_stable = locked_stable_q;
    assign lock_loss_cnt = lock_loss_cnt_q;
`ifdef PLL_RST_CTRL_WATCHDOG_EN
    assign pll_rst = pll_rst_q;
`else
    assign pll_rst = 1'b0;
`endif

endmodule

// File: tb/tb_pll_rst_ctrl.sv
// tb_pll_rst_ctrl: self-checking bench for pll_rst_ctrl with a small
// behavioural model (lock history + count of consecutive seen-lock edges).
module tb_pll_rst_ctrl;
    localparam int LSC = 8;
    localparam int NR  = 3;
    localparam int GAP = 4;
    localparam int LT  = 20;
    localparam int PRC = 5;
    localparam int REL0 = LSC + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pll_lock = 1'b0;
    logic [NR-1:0] rst_n_out;
    logic          locked_stable;
    logic [7:0]    lock_loss_cnt;
    logic          pll_rst;

    int n_cmp = 0;
    int n_bad = 0;

    pll_rst_ctrl #(
        .LOCK_STABLE_CYCLES(LSC), .NUM_RST(NR), .STAGE_GAP(GAP),
        .LOCK_TIMEOUT(LT), .PLL_RST_CYCLES(PRC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock),
        .rst_n_out(rst_n_out), .locked_stable(locked_stable),
        .lock_loss_cnt(lock_loss_cnt), .pll_rst(pll_rst)
    );

    always #5 clk = ~clk;

    // Reference model: the FSM sees the lock value sampled two edges earlier.
    // m_h counts consecutive edges on which it saw lock high; stage k is out of
    // reset once m_h >= LSC+1+k*GAP. A low after release counts as a loss.
    int   m_h;
    int   m_loss;
    logic m_p1, m_p2;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_h = 0; m_loss = 0; m_p1 = 1'b0; m_p2 = 1'b0;
        end else begin
            if (m_p2) begin
                if (m_h < 1000000) m_h = m_h + 1;
            end else begin
                if (m_h >= REL0) m_loss = (m_loss < 255) ? m_loss + 1 : 255;
                m_h = 0;
            end
            m_p2 = m_p1;
            m_p1 = pll_lock;
        end
    end

    function automatic logic [NR-1:0] exp_rst(int h);
        logic [NR-1:0] r;
        for (int k = 0; k < NR; k++) r[k] = (h >= REL0 + k * GAP);
        return r;
    endfunction

    function automatic logic [NR+9:0] want();
        return {exp_rst(m_h), (m_h >= REL0 + (NR - 1) * GAP), 8'(m_loss), 1'b0};
    endfunction

    function automatic logic [NR+9:0] got();
`ifdef PLL_RST_CTRL_WATCHDOG_EN
        return {rst_n_out, locked_stable, lock_loss_cnt, 1'b0};
`else
        return {rst_n_out, locked_stable, lock_loss_cnt, pll_rst};
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pll_lock = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pll_lock = 1'($urandom);
        #1;
        n_cmp++;
        if ({rst_n_out, locked_stable, lock_loss_cnt, pll_rst} !== '0) begin
            n_bad++;
            $display("FAIL reset_immediate: got %h want 0", {rst_n_out, locked_stable, lock_loss_cnt, pll_rst});
        end
        for (int i = 0; i < 3; i++) begin
            pll_lock = 1'($urandom);
            tick();
            n_cmp++;
            if ({rst_n_out, locked_stable, lock_loss_cnt, pll_rst} !== '0) begin
                n_bad++;
                $display("FAIL reset_held: got %h want 0", {rst_n_out, locked_stable, lock_loss_cnt, pll_rst});
            end
        end
        pll_lock = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_clean_release();
        do_reset();
        pll_lock = 1'b1;
        for (int j = 0; j < 24; j++) begin
            tick();
            n_cmp++;
            if ({rst_n_out, locked_stable} !== {j >= 18, j >= 14, j >= 10, j >= 18}) begin
                n_bad++;
                $display("FAIL clean_release t+%0d: got %b/%b want %b/%b", j, rst_n_out, locked_stable,
                         {j >= 18, j >= 14, j >= 10}, j >= 18);
            end
            n_cmp++;
            if (got() !== want()) begin
                n_bad++;
                $display("FAIL clean_model t+%0d: got %h want %h", j, got(), want());
            end
        end
    endtask

    task automatic test_glitch();
        int rise;
        rise = -1;
        do_reset();
        for (int j = 0; j < 36; j++) begin
            pll_lock = !(j >= 5 && j <= 7);
            tick();
            if (rise < 0 && rst_n_out[0]) rise = j;
            n_cmp++;
            if (got() !== want()) begin
                n_bad++;
                $display("FAIL glitch_model t+%0d: got %h want %h", j, got(), want());
            end
        end
        n_cmp++;
        if (rise != 18) begin
            n_bad++;
            $display("FAIL glitch_release_edge: got t+%0d want t+18", rise);
        end
        n_cmp++;
        if (lock_loss_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL glitch_loss_cnt: got %0d want 0", lock_loss_cnt);
        end
    endtask

    task automatic test_loss_in_run();
        do_reset();
        pll_lock = 1'b1;
        for (int i = 0; i < 40 && !locked_stable; i++) tick();
        n_cmp++;
        if (locked_stable !== 1'b1) begin
            n_bad++;
            $display("FAIL loss_reach_run: got %b want 1", locked_stable);
        end
        pll_lock = 1'b0;
        for (int j = 0; j < 4; j++) begin
            tick();
            if (j == 1) begin
                n_cmp++;
                if ({rst_n_out, locked_stable, lock_loss_cnt} !== {{NR{1'b1}}, 1'b1, 8'd0}) begin
                    n_bad++;
                    $display("FAIL loss_t1: got %b/%b/%0d want all-1/1/0", rst_n_out, locked_stable, lock_loss_cnt);
                end
            end else if (j >= 2) begin
                n_cmp++;
                if ({rst_n_out, locked_stable, lock_loss_cnt} !== {{NR{1'b0}}, 1'b0, 8'd1}) begin
                    n_bad++;
                    $display("FAIL loss_t%0d: got %b/%b/%0d want 0/0/1", j, rst_n_out, locked_stable, lock_loss_cnt);
                end
            end
        end
        pll_lock = 1'b1;
        for (int j = 0; j < 24; j++) begin
            tick();
            n_cmp++;
            if ({rst_n_out, locked_stable} !== {j >= 18, j >= 14, j >= 10, j >= 18}) begin
                n_bad++;
                $display("FAIL relock t+%0d: got %b/%b", j, rst_n_out, locked_stable);
            end
            n_cmp++;
            if (got() !== want()) begin
                n_bad++;
                $display("FAIL relock_model t+%0d: got %h want %h", j, got(), want());
            end
        end
    endtask

    task automatic test_saturation();
        bit stuck;
        stuck = 1'b0;
        do_reset();
        for (int ev = 0; ev < 260 && !stuck; ev++) begin
            pll_lock = 1'b1;
            for (int i = 0; i < 40 && !locked_stable; i++) tick();
            pll_lock = 1'b0;
            for (int i = 0; i < 10 && rst_n_out != '0; i++) tick();
            n_cmp++;
            if (got() !== want()) begin
                n_bad++;
                stuck = 1'b1;
                $display("FAIL sat_model ev %0d: got %h want %h", ev, got(), want());
            end
        end
        n_cmp++;
        if (lock_loss_cnt !== 8'd255) begin
            n_bad++;
            $display("FAIL saturation: got %0d want 255", lock_loss_cnt);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        pll_lock = 1'b1;
        for (int i = 0; i < 40 && rst_n_out != 3'b011; i++) tick();
        n_cmp++;
        if (rst_n_out !== 3'b011) begin
            n_bad++;
            $display("FAIL async_reach_bit1: got %b want 011", rst_n_out);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({rst_n_out, locked_stable, lock_loss_cnt, pll_rst} !== '0) begin
            n_bad++;
            $display("FAIL async_reset_now: got %h want 0", {rst_n_out, locked_stable, lock_loss_cnt, pll_rst});
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int j = 0; j < 24; j++) begin
            tick();
            n_cmp++;
            if ({rst_n_out, locked_stable} !== {j >= 18, j >= 14, j >= 10, j >= 18}) begin
                n_bad++;
                $display("FAIL async_rerun t+%0d: got %b/%b", j, rst_n_out, locked_stable);
            end
        end
    endtask

    task automatic test_random();
        int len;
        do_reset();
        for (int seg = 0; seg < 80; seg++) begin
            pll_lock = ~pll_lock;
            len = pll_lock ? $urandom_range(1, 40) : $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                tick();
                n_cmp++;
                if (got() !== want()) begin
                    n_bad++;
                    $display("FAIL random_model seg %0d: got %h want %h", seg, got(), want());
                end
            end
        end
    endtask

    task automatic test_watchdog();
        logic exp_pr;
        do_reset();
        for (int n = 1; n <= 80; n++) begin
            tick();
`ifdef PLL_RST_CTRL_WATCHDOG_EN
            exp_pr = (n >= LT) && (((n - LT) % (LT + PRC)) < PRC);
`else
            exp_pr = 1'b0;
`endif
            n_cmp++;
            if ({pll_rst, rst_n_out} !== {exp_pr, {NR{1'b0}}}) begin
                n_bad++;
                $display("FAIL watchdog n=%0d: got %b/%b want %b/0", n, pll_rst, rst_n_out, exp_pr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_release();
        test_glitch();
        test_loss_in_run();
        test_saturation();
        test_async_reset();
        test_random();
        test_watchdog();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
